// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between retiring units and the register-file write ports.
// Optional forwarding signals exist only when WB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
);
  logic                        stall;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_rd_en;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_r0_en;
  logic [NUM_REQ*DATA_W-1:0]   req_r0_data;

  logic                        registerWrite;
  logic [ADDR_W-1:0]           regWriteLocal;
  logic [DATA_W-1:0]           dataWrite;
  logic                        r0WriteEn;
  logic [DATA_W-1:0]           r0Write;

`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0]           registerRead1;
  logic [ADDR_W-1:0]           registerRead2;
  logic [DATA_W-1:0]           rf_dataRead1;
  logic [DATA_W-1:0]           rf_dataRead2;
  logic [DATA_W-1:0]           fwd_dataRead1;
  logic [DATA_W-1:0]           fwd_dataRead2;
`endif

  modport master (
    output stall, req_valid, req_rd_en, req_addr, req_data, req_r0_en, req_r0_data,
    input  req_ready, registerWrite, regWriteLocal, dataWrite, r0WriteEn, r0Write
`ifdef WB_BYPASS_EN
    , output registerRead1, registerRead2, rf_dataRead1, rf_dataRead2
    , input  fwd_dataRead1, fwd_dataRead2
`endif
  );

  modport slave (
    input  stall, req_valid, req_rd_en, req_addr, req_data, req_r0_en, req_r0_data,
    output req_ready, registerWrite, regWriteLocal, dataWrite, r0WriteEn, r0Write
`ifdef WB_BYPASS_EN
    , input  registerRead1, registerRead2, rf_dataRead1, rf_dataRead2
    , output fwd_dataRead1, fwd_dataRead2
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the 16x16 register file, one grant per cycle,
// registered write strobes. Define WB_BYPASS_EN to add the read-forwarding mux.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_arbiter_if.slave wb
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   grantIdx;
  logic [PTR_W-1:0]   nextPtr;
  logic               grantValid;
  logic               acceptNow;
  logic [NUM_REQ-1:0] grantVec;

  logic               selRdEn;
  logic               selR0En;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selData;
  logic [DATA_W-1:0]  selR0Data;
  logic               rdHitsR0;

  logic               wrEnQ;
  logic [ADDR_W-1:0]  wrAddrQ;
  logic [DATA_W-1:0]  wrDataQ;
  logic               r0EnQ;
  logic [DATA_W-1:0]  r0DataQ;

  // Scan from the highest offset down so the lowest offset from rrPtr wins last.
  always_comb begin : grantSearch
    int cand;
    cand       = 0;
    grantIdx   = '0;
    grantValid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rrPtr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (wb.req_valid[PTR_W'(cand)]) begin
        grantIdx   = PTR_W'(cand);
        grantValid = 1'b1;
      end
    end
  end

  always_comb begin : grantDecode
    grantVec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grantVec[i] = grantValid && (grantIdx == PTR_W'(i));
    end
  end

  assign acceptNow    = grantValid & ~wb.stall & ~reset;
  assign wb.req_ready = acceptNow ? grantVec : '0;
  assign nextPtr      = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);

  always_comb begin : payloadSelect
    selRdEn   = 1'b0;
    selR0En   = 1'b0;
    selAddr   = '0;
    selData   = '0;
    selR0Data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantVec[i]) begin
        selRdEn   = wb.req_rd_en[i];
        selR0En   = wb.req_r0_en[i];
        selAddr   = wb.req_addr[i*ADDR_W +: ADDR_W];
        selData   = wb.req_data[i*DATA_W +: DATA_W];
        selR0Data = wb.req_r0_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A general write to R0 in the same retire as an R0-port write is dropped; R0 port wins.
  assign rdHitsR0 = selR0En && (selAddr == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr   <= '0;
      wrEnQ   <= 1'b0;
      wrAddrQ <= '0;
      wrDataQ <= '0;
      r0EnQ   <= 1'b0;
      r0DataQ <= '0;
    end else if (acceptNow) begin
      rrPtr   <= nextPtr;
      wrEnQ   <= selRdEn & ~rdHitsR0;
      wrAddrQ <= selAddr;
      wrDataQ <= selData;
      r0EnQ   <= selR0En;
      r0DataQ <= selR0Data;
    end else begin
      wrEnQ   <= 1'b0;
      r0EnQ   <= 1'b0;
    end
  end

  assign wb.registerWrite = wrEnQ;
  assign wb.regWriteLocal = wrAddrQ;
  assign wb.dataWrite     = wrDataQ;
  assign wb.r0WriteEn     = r0EnQ;
  assign wb.r0Write       = r0DataQ;

`ifdef WB_BYPASS_EN
  // R0-port data takes precedence over the general port for reads of register 0.
  always_comb begin : forwardMux
    wb.fwd_dataRead1 = wb.rf_dataRead1;
    if ((wb.registerRead1 == '0) && r0EnQ)        wb.fwd_dataRead1 = r0DataQ;
    else if (wrEnQ && (wrAddrQ == wb.registerRead1)) wb.fwd_dataRead1 = wrDataQ;

    wb.fwd_dataRead2 = wb.rf_dataRead2;
    if ((wb.registerRead2 == '0) && r0EnQ)        wb.fwd_dataRead2 = r0DataQ;
    else if (wrEnQ && (wrAddrQ == wb.registerRead2)) wb.fwd_dataRead2 = wrDataQ;
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed write-back scenarios, then randomized traffic against
// a round-robin reference model with a starvation-bound check.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) wb ();
  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .wb(wb)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // requester-side state
  bit          vld[N];
  bit          rdEn[N];
  bit          r0En[N];
  logic [AW-1:0] addr[N];
  logic [DW-1:0] data[N];
  logic [DW-1:0] r0d[N];
  bit          stallIn;
  int          waitCnt[N];

  // reference model: pointer and expected registered outputs
  int          mPtr;
  bit          mRw;
  bit          mR0En;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic [DW-1:0] mR0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    wb.stall = stallIn;
    for (int i = 0; i < N; i++) begin
      wb.req_valid[i]              = vld[i];
      wb.req_rd_en[i]              = rdEn[i];
      wb.req_r0_en[i]              = r0En[i];
      wb.req_addr[i*AW +: AW]      = addr[i];
      wb.req_data[i*DW +: DW]      = data[i];
      wb.req_r0_data[i*DW +: DW]   = r0d[i];
    end
  endtask

  function automatic int firstValid();
    for (int k = 0; k < N; k++) begin
      if (vld[(mPtr + k) % N]) return (mPtr + k) % N;
    end
    return -1;
  endfunction

`ifdef WB_BYPASS_EN
  task automatic bypassCheck(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [DW-1:0] rf1, rf2, e1, e2;
    rf1 = DW'($urandom);
    rf2 = DW'($urandom);
    wb.registerRead1 = a1;
    wb.registerRead2 = a2;
    wb.rf_dataRead1  = rf1;
    wb.rf_dataRead2  = rf2;
    #1;
    e1 = (a1 == 0 && mR0En) ? mR0 : (mRw && mAddr == a1) ? mData : rf1;
    e2 = (a2 == 0 && mR0En) ? mR0 : (mRw && mAddr == a2) ? mData : rf2;
    checkVal("fwd_dataRead1", wb.fwd_dataRead1, e1);
    checkVal("fwd_dataRead2", wb.fwd_dataRead2, e2);
  endtask
`endif

  // One clock: check ready mid-cycle, advance the model at the edge, check outputs after it.
  task automatic step(output int g);
    drive();
    @(negedge clk);
    g = (reset || stallIn) ? -1 : firstValid();
    checkVal("req_ready", wb.req_ready, (g < 0) ? 0 : (1 << g));
    @(posedge clk);
    if (reset) begin
      mPtr = 0; mRw = 0; mR0En = 0; mAddr = '0; mData = '0; mR0 = '0;
    end else if (g >= 0) begin
      mRw   = rdEn[g] && !(addr[g] == 0 && r0En[g]);
      mR0En = r0En[g];
      mAddr = addr[g];
      mData = data[g];
      mR0   = r0d[g];
      mPtr  = (g + 1) % N;
    end else begin
      mRw = 0; mR0En = 0;
    end
    #1;
    checkVal("registerWrite", wb.registerWrite, mRw);
    checkVal("regWriteLocal", wb.regWriteLocal, mAddr);
    checkVal("dataWrite", wb.dataWrite, mData);
    checkVal("r0WriteEn", wb.r0WriteEn, mR0En);
    checkVal("r0Write", wb.r0Write, mR0);
  endtask

  task automatic setReq(input int i, input bit v, input bit rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit r0, input logic [DW-1:0] r0v);
    vld[i] = v; rdEn[i] = rd; addr[i] = a; data[i] = d; r0En[i] = r0; r0d[i] = r0v;
  endtask

  initial begin
    int g;
    int seq[5];
    seq = '{0, 1, 2, 0, 1};
    mPtr = 0; mRw = 0; mR0En = 0; mAddr = '0; mData = '0; mR0 = '0;
    stallIn = 1'b0;
    reset   = 1'b1;
`ifdef WB_BYPASS_EN
    wb.registerRead1 = '0; wb.registerRead2 = '0;
    wb.rf_dataRead1  = '0; wb.rf_dataRead2  = '0;
`endif

    // reset with every requester valid, then accept followed by reset
    for (int i = 0; i < N; i++) setReq(i, 1, 1, AW'(i + 3), DW'(16'h1000 + i), 1, DW'(16'h2000 + i));
    step(g);
    step(g);
    reset = 1'b0;
    step(g);
    checkVal("t1_acceptWr", wb.registerWrite, 1);
    reset = 1'b1;
    step(g);
    checkVal("t1_resetWr", wb.registerWrite, 0);
    checkVal("t1_resetR0", wb.r0WriteEn, 0);

    // single requester, strobe for exactly one cycle
    reset = 1'b0;
    for (int i = 0; i < N; i++) vld[i] = 0;
    setReq(1, 1, 1, 4'd7, 16'hABCD, 0, 16'h0);
    step(g);
    checkVal("t2_wr", wb.registerWrite, 1);
    checkVal("t2_addr", wb.regWriteLocal, 7);
    checkVal("t2_data", wb.dataWrite, 16'hABCD);
`ifdef WB_BYPASS_EN
    bypassCheck(4'd7, 4'd8);
    checkVal("t6_fwd1", wb.fwd_dataRead1, 16'hABCD);
`endif
    vld[1] = 0;
    step(g);
    checkVal("t2_oneCycle", wb.registerWrite, 0);

    // all valid from reset: strict rotation
    reset = 1'b1;
    for (int i = 0; i < N; i++) setReq(i, 1, 1, AW'(i + 1), DW'(16'h3000 + i), 0, 16'h0);
    step(g);
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step(g);
      checkVal("t3_wr", wb.registerWrite, 1);
      checkVal("t3_order", wb.regWriteLocal, seq[j] + 1);
    end

    // dual write, then R0 conflict
    for (int i = 0; i < N; i++) vld[i] = 0;
    setReq(2, 1, 1, 4'd5, 16'h1234, 1, 16'hAAAA);
    step(g);
    checkVal("t4_wr", wb.registerWrite, 1);
    checkVal("t4_addr", wb.regWriteLocal, 5);
    checkVal("t4_data", wb.dataWrite, 16'h1234);
    checkVal("t4_r0En", wb.r0WriteEn, 1);
    checkVal("t4_r0", wb.r0Write, 16'hAAAA);
    addr[2] = 4'd0;
    step(g);
    checkVal("t4_conflictWr", wb.registerWrite, 0);
    checkVal("t4_conflictR0", wb.r0Write, 16'hAAAA);
`ifdef WB_BYPASS_EN
    bypassCheck(4'd0, 4'd5);
    checkVal("t6_fwdR0", wb.fwd_dataRead1, 16'hAAAA);
`endif
    vld[2] = 0;

    // stall holds pointer and blocks grants
    reset = 1'b1;
    step(g);
    reset = 1'b0;
    setReq(0, 1, 1, 4'd9, 16'h0909, 0, 16'h0);
    setReq(2, 1, 1, 4'd10, 16'h0A0A, 0, 16'h0);
    stallIn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(g);
      checkVal("t5_stallWr", wb.registerWrite, 0);
    end
    stallIn = 1'b0;
    step(g);
    checkVal("t5_first", wb.regWriteLocal, 9);
    vld[0] = 0;
    step(g);
    checkVal("t5_second", wb.regWriteLocal, 10);
    vld[2] = 0;

    // randomized traffic
    for (int i = 0; i < N; i++) waitCnt[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stallIn = ($urandom_range(0, 99) < 20);
      reset   = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          setReq(i, 1, 1'($urandom), ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom),
                 DW'($urandom), 1'($urandom), DW'($urandom));
          waitCnt[i] = 0;
        end
      end
      step(g);
      if (reset) begin
        for (int i = 0; i < N; i++) waitCnt[i] = 0;
      end else if (!stallIn) begin
        for (int i = 0; i < N; i++) if (vld[i] && i != g) waitCnt[i]++;
      end
      if (g >= 0) begin
        checkVal("starvation", (waitCnt[g] < N) ? 1 : 0, 1);
        vld[g] = 0;
      end
`ifdef WB_BYPASS_EN
      bypassCheck(AW'($urandom), ($urandom_range(0, 1) == 1) ? mAddr : AW'(0));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
